// File: rtl/i2s_rx_deserializer.sv
// I2S slave receiver: synchronizes SCLK/WS/SD into clk, deserializes DATA_W-bit slots and queues them in a FWFT FIFO.
// Optional macro I2S_RX_LEFT_ONLY_EN: keep only left-channel (ws = 0) words; sample_chan tied to 0.
module i2s_rx_deserializer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk_in,
    input  logic              ws_in,
    input  logic              sd_in,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_chan,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [2:0]        r_sclkSync;
    logic [1:0]        r_wsSync;
    logic [1:0]        r_sdSync;
    logic              r_wsPrev;
    state_t            r_state;
    logic [CW-1:0]     r_bitCnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_pushEn;
    logic [DATA_W-1:0] r_pushWord;
    logic              r_frameErr;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wrPtr;
    logic [AW:0]       r_rdPtr;
    logic              r_overflow;

    state_t            w_nextState;
    logic [CW-1:0]     w_nextBitCnt;
    logic [DATA_W-1:0] w_nextShreg;
    logic              w_wordDone;
    logic              w_wordErr;
    logic              w_pushReq;
    logic [DATA_W-1:0] w_word;
    logic              w_rise;
    logic              w_ws;
    logic              w_sd;
    logic              w_wsChange;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_write;
    logic              w_drop;

    assign w_rise     = r_sclkSync[1] & ~r_sclkSync[2];
    assign w_ws       = r_wsSync[1];
    assign w_sd       = r_sdSync[1];
    assign w_wsChange = w_rise & (w_ws != r_wsPrev);
    assign w_word     = {r_shreg[DATA_W-2:0], w_sd};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclkSync <= '0;
            r_wsSync   <= '0;
            r_sdSync   <= '0;
            r_wsPrev   <= 1'b0;
        end else begin
            r_sclkSync <= {r_sclkSync[1:0], sclk_in};
            r_wsSync   <= {r_wsSync[0], ws_in};
            r_sdSync   <= {r_sdSync[0], sd_in};
            if (w_rise) begin
                r_wsPrev <= w_ws;
            end
        end
    end

    // A WS change marks the LSB of the finishing slot; only a full-length slot yields a word.
    always_comb begin
        w_nextState  = r_state;
        w_nextBitCnt = r_bitCnt;
        w_nextShreg  = r_shreg;
        w_wordDone   = 1'b0;
        w_wordErr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wsChange) begin
                    w_nextBitCnt = '0;
                    w_nextState  = SHIFT;
                end
            end
            SHIFT: begin
                if (w_wsChange) begin
                    w_nextBitCnt = '0;
                    if (r_bitCnt == CW'(DATA_W - 1)) begin
                        w_wordDone = 1'b1;
                    end else begin
                        w_wordErr = 1'b1;
                    end
                end else if (w_rise) begin
                    w_nextShreg = {r_shreg[DATA_W-2:0], w_sd};
                    if (r_bitCnt != CW'(DATA_W)) begin
                        w_nextBitCnt = r_bitCnt + 1'b1;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

`ifdef I2S_RX_LEFT_ONLY_EN
    assign w_pushReq = w_wordDone & ~r_wsPrev;
`else
    assign w_pushReq = w_wordDone;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bitCnt   <= '0;
            r_shreg    <= '0;
            r_pushEn   <= 1'b0;
            r_pushWord <= '0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_bitCnt   <= w_nextBitCnt;
            r_shreg    <= w_nextShreg;
            r_pushEn   <= w_pushReq;
            r_frameErr <= w_wordErr;
            if (w_wordDone) begin
                r_pushWord <= w_word;
            end
        end
    end

    // Extra pointer bit distinguishes full from empty; a pop frees the slot a same-cycle push needs.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
    assign w_pop   = ~w_empty & sample_ready;
    assign w_write = r_pushEn & (~w_full | w_pop);
    assign w_drop  = r_pushEn & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_wrPtr[AW-1:0]] <= r_pushWord;
                r_wrPtr                <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_LEFT_ONLY_EN
    assign sample_chan = 1'b0;
`else
    logic              r_pushChan;
    logic              r_chanMem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pushChan <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_chanMem[i] <= 1'b0;
            end
        end else begin
            if (w_wordDone) begin
                r_pushChan <= r_wsPrev;
            end
            if (w_write) begin
                r_chanMem[r_wrPtr[AW-1:0]] <= r_pushChan;
            end
        end
    end

    assign sample_chan = r_chanMem[r_rdPtr[AW-1:0]];
`endif

    assign sample_data  = r_mem[r_rdPtr[AW-1:0]];
    assign sample_valid = ~w_empty;
    assign overflow     = r_overflow;
    assign frame_err    = r_frameErr;

endmodule
